mem_seq: RTL and testbench

//  Memory-cycle sequencer for the CISC core. Accepts one read/write request at a time
//  and sequences MAR load, the MDR ld/source select, memory strobes and wait states.

---
 rtl/mem_seq.sv | 166 ++++++++++++++++
 tb/tb_mem_seq.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mem_seq.sv
// rtl/mem_seq.sv - memory-cycle sequencer: MAR/MDR load, strobes, wait states, done pulse.
// Optional wait-state timeout and ERR state enabled by defining MEM_SEQ_TIMEOUT_EN.
module mem_seq #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_req,
  input  logic i_we,
  input  logic i_mem_rdy,
  output logic o_busy,
  output logic o_done,
  output logic o_err,
  output logic o_mar_ld,
  output logic o_mdr_ld,
  output logic o_mdr_sel,
  output logic o_mem_rd,
  output logic o_mem_wr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_RD_WAIT,
    S_RD_LATCH,
    S_WR_LOAD,
    S_WR_WAIT,
`ifdef MEM_SEQ_TIMEOUT_EN
    S_DONE,
    S_ERR
`else
    S_DONE
`endif
  } state_t;

  localparam logic [7:0] LP_WAIT = 8'(WAIT_CYCLES);

  state_t     r_state;
  state_t     w_next;
  logic       r_we;
  logic [7:0] r_wcnt;
  logic       w_wait_ok;
  logic       w_wait_entry;
  logic       w_in_wait;

  assign w_wait_ok    = (r_wcnt == 8'd0) && i_mem_rdy;
  assign w_in_wait    = (r_state == S_RD_WAIT) || (r_state == S_WR_WAIT);
  assign w_wait_entry = ((w_next == S_RD_WAIT) && (r_state != S_RD_WAIT)) ||
                        ((w_next == S_WR_WAIT) && (r_state != S_WR_WAIT));

`ifdef MEM_SEQ_TIMEOUT_EN
  localparam logic [7:0] LP_TLAST = 8'(TIMEOUT - 1);
  logic [7:0] r_tcnt;
  logic       r_err;
  logic       w_tmo;

  // tcnt counts strobe cycles already spent; the last allowed one is TIMEOUT-1.
  assign w_tmo = (r_tcnt == LP_TLAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tcnt <= 8'd0;
    end else if (w_wait_entry) begin
      r_tcnt <= 8'd0;
    end else if (w_in_wait && (r_tcnt != 8'hFF)) begin
      r_tcnt <= r_tcnt + 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_err <= 1'b0;
    end else if (w_next == S_ERR) begin
      r_err <= 1'b1;
    end else if (w_next == S_ADDR) begin
      r_err <= 1'b0;
    end
  end

  assign o_err = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign o_err = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (i_req) w_next = S_ADDR;
      S_ADDR:     w_next = r_we ? S_WR_LOAD : S_RD_WAIT;
      S_RD_WAIT: begin
        if (w_wait_ok) w_next = S_RD_LATCH;
`ifdef MEM_SEQ_TIMEOUT_EN
        else if (w_tmo) w_next = S_ERR;
`endif
      end
      S_RD_LATCH: w_next = S_DONE;
      S_WR_LOAD:  w_next = S_WR_WAIT;
      S_WR_WAIT: begin
        if (w_wait_ok) w_next = S_DONE;
`ifdef MEM_SEQ_TIMEOUT_EN
        else if (w_tmo) w_next = S_ERR;
`endif
      end
      S_DONE:     w_next = S_IDLE;
`ifdef MEM_SEQ_TIMEOUT_EN
      S_ERR:      w_next = S_IDLE;
`endif
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_we <= 1'b0;
    end else if ((r_state == S_IDLE) && i_req) begin
      r_we <= i_we;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wcnt <= 8'd0;
    end else if (w_wait_entry) begin
      r_wcnt <= LP_WAIT;
    end else if (w_in_wait && (r_wcnt != 8'd0)) begin
      r_wcnt <= r_wcnt - 8'd1;
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_mar_ld  <= 1'b0;
      o_mdr_ld  <= 1'b0;
      o_mdr_sel <= 1'b0;
      o_mem_rd  <= 1'b0;
      o_mem_wr  <= 1'b0;
    end else begin
      o_busy    <= (w_next != S_IDLE);
`ifdef MEM_SEQ_TIMEOUT_EN
      o_done    <= (w_next == S_DONE) || (w_next == S_ERR);
`else
      o_done    <= (w_next == S_DONE);
`endif
      o_mar_ld  <= (w_next == S_ADDR);
      o_mdr_ld  <= (w_next == S_RD_LATCH) || (w_next == S_WR_LOAD);
      o_mdr_sel <= (w_next == S_WR_LOAD) || (w_next == S_WR_WAIT);
      o_mem_rd  <= (w_next == S_RD_WAIT) || (w_next == S_RD_LATCH);
      o_mem_wr  <= (w_next == S_WR_WAIT);
    end
  end

endmodule

// File: tb/tb_mem_seq.sv
// tb/tb_mem_seq.sv - table-driven and directed checks for mem_seq (WAIT_CYCLES=2, TIMEOUT=64).
module tb_mem_seq;

  // Expected output word: {busy, done, err, mar_ld, mdr_ld, mdr_sel, mem_rd, mem_wr}
  localparam logic [7:0] E_IDLE  = 8'b0000_0000;
  localparam logic [7:0] E_ADDR  = 8'b1001_0000;
  localparam logic [7:0] E_RDW   = 8'b1000_0010;
  localparam logic [7:0] E_RDL   = 8'b1000_1010;
  localparam logic [7:0] E_WRL   = 8'b1000_1100;
  localparam logic [7:0] E_WRW   = 8'b1000_0101;
  localparam logic [7:0] E_DONE  = 8'b1100_0000;
  localparam logic [7:0] E_ERR   = 8'b1110_0000;
  localparam logic [7:0] E_ERRI  = 8'b0010_0000;

  typedef struct {
    logic       rst;
    logic       req;
    logic       we;
    logic       rdy;
    logic [7:0] exp;
    string      name;
  } vec_t;

  logic clk = 1'b0;
  logic reset, req, we, mem_rdy;
  logic busy, done, err, mar_ld, mdr_ld, mdr_sel, mem_rd, mem_wr;

  int n_vec  = 0;
  int n_miss = 0;
  int rd_cycles = 0;
  int ld_pulses = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  mem_seq #(.WAIT_CYCLES(2), .TIMEOUT(64)) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_req     (req),
    .i_we      (we),
    .i_mem_rdy (mem_rdy),
    .o_busy    (busy),
    .o_done    (done),
    .o_err     (err),
    .o_mar_ld  (mar_ld),
    .o_mdr_ld  (mdr_ld),
    .o_mdr_sel (mdr_sel),
    .o_mem_rd  (mem_rd),
    .o_mem_wr  (mem_wr)
  );

  task automatic add(input logic rst, input logic rq, input logic w, input logic rdy,
                     input logic [7:0] exp, input string name);
    vec_t v;
    v.rst = rst; v.req = rq; v.we = w; v.rdy = rdy; v.exp = exp; v.name = name;
    tbl.push_back(v);
  endtask

  task automatic check(input logic [31:0] act, input logic [31:0] exp, input string name);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic rq, input logic w, input logic rdy,
                      input logic [7:0] exp, input string name);
    logic [7:0] act;
    reset = rst; req = rq; we = w; mem_rdy = rdy;
    @(posedge clk);
    #1;
    act = {busy, done, err, mar_ld, mdr_ld, mdr_sel, mem_rd, mem_wr};
    if (mem_rd) rd_cycles++;
    if (mdr_ld) ld_pulses++;
    check({24'd0, act}, {24'd0, exp}, name);
  endtask

  initial begin
    reset = 1'b1; req = 1'b1; we = 1'b0; mem_rdy = 1'b1;

    // reset with req high, then release and stay idle
    add(1, 1, 0, 1, E_IDLE, "reset0");
    add(1, 1, 0, 1, E_IDLE, "reset1");
    add(0, 0, 0, 1, E_IDLE, "idle0");
    add(0, 0, 0, 1, E_IDLE, "idle1");
    // read, W=2, mem_rdy high; req held into DONE must not start a new cycle
    add(0, 1, 0, 1, E_ADDR, "rd_addr");
    add(0, 1, 0, 1, E_RDW,  "rd_wait0");
    add(0, 1, 0, 1, E_RDW,  "rd_wait1");
    add(0, 1, 0, 1, E_RDW,  "rd_wait2");
    add(0, 1, 0, 1, E_RDL,  "rd_latch");
    add(0, 1, 0, 1, E_DONE, "rd_done");
    add(0, 1, 0, 1, E_IDLE, "rd_no_req_in_done");
    add(0, 0, 0, 1, E_IDLE, "rd_idle");
    // write, W=2; we flips after acceptance and must be ignored
    add(0, 1, 1, 1, E_ADDR, "wr_addr");
    add(0, 1, 0, 1, E_WRL,  "wr_load");
    add(0, 1, 0, 1, E_WRW,  "wr_wait0");
    add(0, 1, 0, 1, E_WRW,  "wr_wait1");
    add(0, 1, 0, 1, E_WRW,  "wr_wait2");
    add(0, 1, 0, 1, E_DONE, "wr_done");
    add(0, 0, 0, 1, E_IDLE, "wr_idle");

    foreach (tbl[i]) step(tbl[i].rst, tbl[i].req, tbl[i].we, tbl[i].rdy, tbl[i].exp, tbl[i].name);

    // read with mem_rdy low for 10 wait cycles: 12 mem_rd cycles, one mdr_ld
    rd_cycles = 0; ld_pulses = 0;
    step(0, 1, 0, 0, E_ADDR, "slow_addr");
    for (int i = 0; i < 11; i++) step(0, 1, 0, 0, E_RDW, "slow_wait");
    step(0, 1, 0, 1, E_RDL,  "slow_latch");
    step(0, 1, 0, 1, E_DONE, "slow_done");
    step(0, 0, 0, 1, E_IDLE, "slow_idle");
    check(rd_cycles, 12, "slow_rd_cycles");
    check(ld_pulses, 1,  "slow_mdr_ld_pulses");

    // reset in WR_WAIT drops strobe and busy on the same edge, then a clean read
    step(0, 1, 1, 0, E_ADDR, "rst_wr_addr");
    step(0, 1, 1, 0, E_WRL,  "rst_wr_load");
    step(0, 1, 1, 0, E_WRW,  "rst_wr_wait");
    step(1, 1, 1, 0, E_IDLE, "rst_mid_write");
    step(0, 0, 0, 1, E_IDLE, "rst_after_idle");
    step(0, 1, 0, 1, E_ADDR, "rst_rd_addr");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, E_RDW, "rst_rd_wait");
    step(0, 1, 0, 1, E_RDL,  "rst_rd_latch");
    step(0, 1, 0, 1, E_DONE, "rst_rd_done");
    step(0, 0, 0, 1, E_IDLE, "rst_rd_idle");

`ifdef MEM_SEQ_TIMEOUT_EN
    // write never acknowledged: 64 strobe cycles, ERR with done, sticky err until next req
    step(0, 1, 1, 0, E_ADDR, "tmo_addr");
    step(0, 1, 1, 0, E_WRL,  "tmo_load");
    for (int i = 0; i < 64; i++) step(0, 1, 1, 0, E_WRW, "tmo_wait");
    step(0, 1, 1, 0, E_ERR,  "tmo_err");
    step(0, 0, 0, 0, E_ERRI, "tmo_err_sticky0");
    step(0, 0, 0, 0, E_ERRI, "tmo_err_sticky1");
    step(0, 1, 0, 1, E_ADDR, "tmo_err_clear");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, E_RDW, "tmo_rd_wait");
    step(0, 1, 0, 1, E_RDL,  "tmo_rd_latch");
    step(0, 1, 0, 1, E_DONE, "tmo_rd_done");
    step(0, 0, 0, 1, E_IDLE, "tmo_rd_idle");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
